// File: rtl/rank_order_pkg.sv
// Shared definitions for the rank-order filter and its sample sink.
// Default sizes, the clog2 helper and the {wf,last} tag bundle.
package rank_order_pkg;

    localparam int N_DEF         = 3;
    localparam int DATA_BITS_DEF = 8;
    localparam int TAG_W         = 2;

    typedef struct packed {
        logic wf;
        logic last;
    } tag_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and an occupancy count.
// Pointers carry one extra bit so full and empty differ only in the MSB.
module sync_fifo
    import rank_order_pkg::*;
#(
    parameter int W     = 9,
    parameter int DEPTH = 4,
    parameter int PW    = clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic          full,
    output logic          empty,
    output logic [PW-1:0] count
);

    localparam int AW = PW - 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

    // A write into a full FIFO is only accepted when the head leaves too.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Storage array; cleared on reset so the head reads zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Read and write pointers, wrapping naturally at 2*DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PW'(1);
            if (do_rd) rd_ptr <= rd_ptr + PW'(1);
        end
    end

endmodule

// File: rtl/rank_order_sink.sv
// Reader end of the rank-order filter stream: keeps full-window results,
// queues them, and grants credit to the source so nothing is lost.
module rank_order_sink
    import rank_order_pkg::*;
#(
    parameter int N         = N_DEF,
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int LAT       = 1,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] filt_out,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 o_ovf
);

    localparam int CNT_W = clog2(N + 1);
    localparam int PW    = clog2(DEPTH) + 1;
    localparam int IW    = clog2(LAT + 1) + 1;
    localparam int CW    = clog2(DEPTH + LAT + 1) + 1;
    localparam int FW    = DATA_BITS + 1;

    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic                  wf;
    tag_t [LAT-1:0]        pipe_q;
    tag_t                  tag_out;
    logic [IW-1:0]         inflight_q;
    logic                  live_q;
    logic                  ovf_q;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [PW-1:0]         occ;
    logic [CW-1:0]         used;
    logic [FW-1:0]         head;

    // Window is full when this sample completes N consecutive valid ones.
    assign wf = in_valid && ((int'(cnt_q) + 1) >= N);

    // Next run count: gaps and frame ends restart the window.
    always_comb begin
        cnt_d = cnt_q;
        if (!in_valid) begin
            cnt_d = '0;
        end else if (in_last) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_W'(N)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Run count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    // Tag pipe mirrors the filter latency so tags meet their results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= tag_t'{wf: wf, last: in_valid && in_last};
            for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign tag_out = pipe_q[LAT-1];
    assign push    = tag_out.wf;

    // Count of full-window tags still travelling through the filter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) inflight_q <= '0;
        else      inflight_q <= inflight_q + IW'(wf) - IW'(tag_out.wf);
    end

    // Holds in_ready low until the first clock after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) live_q <= 1'b0;
        else      live_q <= 1'b1;
    end

    // Sticky flag for a result dropped at a full FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                      ovf_q <= 1'b0;
        else if (push && full && !pop) ovf_q <= 1'b1;
    end

    sync_fifo #(
        .W     (FW),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data ({filt_out, tag_out.last}),
        .rd_en   (out_ready),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (occ)
    );

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign out_data  = head[FW-1:1];
    assign out_last  = head[0];
    assign o_ovf     = ovf_q;

    // Credit uses registered occupancy only, so out_ready never reaches in_ready.
    assign used     = CW'(occ) + CW'(inflight_q);
    assign in_ready = live_q && (used < CW'(DEPTH));

endmodule
